// File: rtl/disp_arbiter.sv
// Three-way display arbiter: requester 0 (self-test) has absolute priority, requesters 1/2
// share the display round-robin with a hold limit, and every ownership change is blanked.
module disp_arbiter #(
   parameter int unsigned MAX_HOLD = 100000000,
   parameter int unsigned GAP_CYC  = 1
) (
   input  logic         clk,
   input  logic         sw,
   input  logic [2:0]   req,
   input  logic [383:0] mat_in,
   input  logic [95:0]  num_in,
   input  logic [2:0]   beep_in,
   output logic [2:0]   gnt,
   output logic [127:0] matrixData,
   output logic [31:0]  numbersData,
   output logic         beep,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

   // Last hold_cnt value allowed while contended; MAX_HOLD of 0 behaves like 1.
   localparam logic [31:0] HoldLast = (MAX_HOLD <= 1) ? 32'd0 : 32'(MAX_HOLD - 1);
   localparam logic [3:0]  GapLast  = 4'(GAP_CYC - 1);

   state_e      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic        rr_q, rr_d;
   logic [31:0] hold_q, hold_d;
   logic [3:0]  gap_q, gap_d;

   logic [2:0]  win;
   logic [2:0]  other;
   logic        release_own;
   logic        grab;

   always_comb begin
      win = 3'b000;
      if (req[0]) begin
         win = 3'b001;
      end else if (req[1] && (!req[2] || !rr_q)) begin
         win = 3'b010;
      end else if (req[2]) begin
         win = 3'b100;
      end
   end

   // Competing function requester for the current owner (none when owner is 0).
   assign other = {gnt_q[1], gnt_q[2], 1'b0};

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_d        = rr_q;
      hold_d      = hold_q;
      gap_d       = gap_q;
      grab        = 1'b0;
      release_own = 1'b0;
      unique case (state_q)
         StIdle: begin
            grab = |req;
         end
         StOwn: begin
            if (hold_q != 32'hFFFF_FFFF) hold_d = hold_q + 32'd1;
            release_own = ((gnt_q & req) == 3'b000) ||
                          (!gnt_q[0] && (req[0] || ((|(other & req)) && hold_q >= HoldLast)));
            if (release_own) begin
               state_d = StGap;
               gnt_d   = 3'b000;
               gap_d   = 4'd0;
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               grab = |req;
               if (!(|req)) state_d = StIdle;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (grab) begin
         state_d = StOwn;
         gnt_d   = win;
         hold_d  = 32'd0;
         if (win[1]) rr_d = 1'b1;
         if (win[2]) rr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!sw) begin
         state_q <= StIdle;
         gnt_q   <= 3'b000;
         rr_q    <= 1'b0;
         hold_q  <= 32'd0;
         gap_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      matrixData  = 128'h0;
      numbersData = 32'hFFFF_FFFF;
      beep        = 1'b0;
      unique case (gnt_q)
         3'b001: begin
            matrixData  = mat_in[127:0];
            numbersData = num_in[31:0];
            beep        = beep_in[0];
         end
         3'b010: begin
            matrixData  = mat_in[255:128];
            numbersData = num_in[63:32];
            beep        = beep_in[1];
         end
         3'b100: begin
            matrixData  = mat_in[383:256];
            numbersData = num_in[95:64];
            beep        = beep_in[2];
         end
         default: ;
      endcase
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: three instances (GAP_CYC=1, GAP_CYC=3, MAX_HOLD=0)
// share stimulus; expectations are queued when driven and compared after each edge.
module tb_disp_arbiter;

   logic         clk = 1'b0;
   logic         sw;
   logic [2:0]   req;
   logic [383:0] mat_in;
   logic [95:0]  num_in;
   logic [2:0]   beep_in;

   logic [2:0]   gnt_a, gnt_b, gnt_c;
   logic [127:0] mat_a, mat_b, mat_c;
   logic [31:0]  num_a, num_b, num_c;
   logic         beep_a, beep_b, beep_c;
   logic         busy_a, busy_b, busy_c;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   disp_arbiter #(.MAX_HOLD(4), .GAP_CYC(1)) dut_a (
      .clk(clk), .sw(sw), .req(req), .mat_in(mat_in), .num_in(num_in), .beep_in(beep_in),
      .gnt(gnt_a), .matrixData(mat_a), .numbersData(num_a), .beep(beep_a), .busy(busy_a)
   );

   disp_arbiter #(.MAX_HOLD(4), .GAP_CYC(3)) dut_b (
      .clk(clk), .sw(sw), .req(req), .mat_in(mat_in), .num_in(num_in), .beep_in(beep_in),
      .gnt(gnt_b), .matrixData(mat_b), .numbersData(num_b), .beep(beep_b), .busy(busy_b)
   );

   disp_arbiter #(.MAX_HOLD(0), .GAP_CYC(1)) dut_c (
      .clk(clk), .sw(sw), .req(req), .mat_in(mat_in), .num_in(num_in), .beep_in(beep_in),
      .gnt(gnt_c), .matrixData(mat_c), .numbersData(num_c), .beep(beep_c), .busy(busy_c)
   );

   typedef struct {
      int         dut;
      logic [2:0] gnt;
      logic       busy;
      string      tag;
   } exp_t;

   typedef struct {
      logic       sw;
      logic [2:0] req;
      logic [2:0] gnt;
      logic       busy;
      string      tag;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];

   task automatic v(input logic s, input logic [2:0] r, input logic [2:0] g, input logic b,
                    input string tag);
      vec_t x;
      x.sw = s; x.req = r; x.gnt = g; x.busy = b; x.tag = tag;
      vt.push_back(x);
   endtask

   task automatic check_one();
      exp_t         e;
      logic [2:0]   ag;
      logic [127:0] am, em;
      logic [31:0]  an, en;
      logic         ab, eb, au;
      e = sb.pop_front();
      case (e.dut)
         0:       begin ag = gnt_a; am = mat_a; an = num_a; ab = beep_a; au = busy_a; end
         1:       begin ag = gnt_b; am = mat_b; an = num_b; ab = beep_b; au = busy_b; end
         default: begin ag = gnt_c; am = mat_c; an = num_c; ab = beep_c; au = busy_c; end
      endcase
      em = 128'h0;
      en = 32'hFFFF_FFFF;
      eb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (e.gnt[i]) begin
            em = mat_in[128*i +: 128];
            en = num_in[32*i +: 32];
            eb = beep_in[i];
         end
      end
      n_chk++;
      if (ag === e.gnt && au === e.busy && am === em && an === en && ab === eb) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got gnt=%b busy=%b num=%h beep=%b mat=%h, want gnt=%b busy=%b num=%h beep=%b mat=%h",
                  e.tag, ag, au, an, ab, am, e.gnt, e.busy, en, eb, em);
      end
   endtask

   task automatic step(input int dut, input logic s, input logic [2:0] r, input logic [2:0] g,
                       input logic b, input string tag);
      exp_t e;
      sw  = s;
      req = r;
      e.dut = dut; e.gnt = g; e.busy = b; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_one();
   endtask

   initial begin
      sw      = 1'b0;
      req     = 3'b000;
      mat_in  = {128'hC3C3_0000_FFFF_1234_5678_9ABC_DEF0_0F0F,
                 128'h8001_4002_2004_1008_0810_0420_0240_0180,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
      num_in  = {32'h2222_2222, 32'h1111_1111, 32'h0000_0AB0};
      beep_in = 3'b101;

      // Reset, REQ-033 rotation with hold limit 4, release/rise handover, preemption by 0,
      // long self-test hold, and sw pulse mid-OWN.
      v(0, 3'b000, 3'b000, 0, "reset");
      v(0, 3'b010, 3'b000, 0, "req_ignored_in_reset");
      v(1, 3'b000, 3'b000, 0, "idle_blank");
      for (int i = 0; i < 4; i++) v(1, 3'b110, 3'b010, 1, "hold_own1");
      v(1, 3'b110, 3'b000, 1, "limit_gap1");
      for (int i = 0; i < 4; i++) v(1, 3'b110, 3'b100, 1, "hold_own2");
      v(1, 3'b110, 3'b000, 1, "limit_gap2");
      v(1, 3'b110, 3'b010, 1, "rr_back_to_1");
      v(1, 3'b000, 3'b000, 1, "drop_gap");
      v(1, 3'b000, 3'b000, 0, "back_idle");
      v(1, 3'b010, 3'b010, 1, "grant1");
      v(1, 3'b100, 3'b000, 1, "drop1_rise2_gap");
      v(1, 3'b100, 3'b100, 1, "handover2");
      v(1, 3'b101, 3'b000, 1, "preempt_gap");
      for (int i = 0; i < 21; i++) v(1, 3'b101, 3'b001, 1, "selftest_hold");
      v(1, 3'b100, 3'b000, 1, "selftest_done_gap");
      v(1, 3'b100, 3'b100, 1, "regrant2");
      v(1, 3'b010, 3'b000, 1, "own2_drop_gap");
      v(1, 3'b010, 3'b010, 1, "grant1_again");
      v(1, 3'b010, 3'b010, 1, "own1_uncontended");
      v(0, 3'b010, 3'b000, 0, "sw_low_mid_own");
      v(1, 3'b110, 3'b010, 1, "rr_reset_grant1");

      for (int i = 0; i < vt.size(); i++) step(0, vt[i].sw, vt[i].req, vt[i].gnt, vt[i].busy,
                                                vt[i].tag);

      // GAP_CYC=3: requests inside the gap only count at its last cycle.
      step(1, 0, 3'b000, 3'b000, 0, "b_reset");
      step(1, 1, 3'b010, 3'b010, 1, "b_grant1");
      step(1, 1, 3'b000, 3'b000, 1, "b_gap1");
      step(1, 1, 3'b001, 3'b000, 1, "b_gap2_toggle");
      step(1, 1, 3'b000, 3'b000, 1, "b_gap3_toggle");
      step(1, 1, 3'b100, 3'b100, 1, "b_winner_final");
      step(1, 1, 3'b000, 3'b000, 1, "b_gap1_again");
      step(1, 1, 3'b110, 3'b000, 1, "b_gap2_req");
      step(1, 1, 3'b001, 3'b000, 1, "b_gap3_req");
      step(1, 1, 3'b000, 3'b000, 0, "b_final_zero_idle");
      step(1, 1, 3'b000, 3'b000, 0, "b_stay_idle");

      // MAX_HOLD=0 acts as 1: contended owner switches after one cycle.
      step(2, 0, 3'b000, 3'b000, 0, "c_reset");
      step(2, 1, 3'b110, 3'b010, 1, "c_grant1");
      step(2, 1, 3'b110, 3'b000, 1, "c_forced_gap1");
      step(2, 1, 3'b110, 3'b100, 1, "c_grant2");
      step(2, 1, 3'b110, 3'b000, 1, "c_forced_gap2");
      step(2, 1, 3'b110, 3'b010, 1, "c_grant1_again");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   always @(negedge clk) begin
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1 || $countones(gnt_c) > 1) begin
         n_chk++;
         $display("FAIL onehot: gnt_a=%b gnt_b=%b gnt_c=%b, want at most one bit set",
                  gnt_a, gnt_b, gnt_c);
      end
   end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 100000000, meaning the maximum grant length in clk cycles for requesters 1/2 while the other is waiting.
REQ-002 The block SHALL have parameter GAP_CYC, default 1, meaning the number of blanked clk cycles inserted between owners (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port sw, input, 1 bit: the master switch, acting as a synchronous active-low reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port req, input, 3 bits: level requests; bit0 is self-test, bits 1/2 are function displays.
REQ-006 The block SHALL have port mat_in, input, 384 bits: three 128-bit matrix images, requester i at [128i+127:128i].
REQ-007 The block SHALL have port num_in, input, 96 bits: three 32-bit digit words, requester i at [32i+31:32i].
REQ-008 The block SHALL have port beep_in, input, 3 bits: per-requester buzzer.
REQ-009 The block SHALL have port gnt, output, 3 bits: one-hot grant, or zero.
REQ-010 The block SHALL have port matrixData, output, 128 bits: the selected matrix image.
REQ-011 The block SHALL have port numbersData, output, 32 bits: the selected digit word.
REQ-012 The block SHALL have port beep, output, 1 bit: the selected buzzer.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, OWN, GAP.
REQ-015 IDLE: gnt=0; on any req bit high, go to OWN the next cycle, granting the winner per REQ-016.
REQ-016 Winner selection SHALL be as follows: req[0] wins unconditionally; otherwise, between req[1] and req[2], round-robin with pointer rr (0 selects requester 1 first, 1 selects requester 2 first).
REQ-017 On granting requester 1 or 2, rr SHALL point to the other requester; granting requester 0 SHALL leave rr unchanged.
REQ-018 OWN: gnt SHALL be held one-hot and hold_cnt (32-bit) SHALL increment each cycle, saturating at 2^32-1.
REQ-019 OWN SHALL exit to GAP when any of the following holds: (a) the owner's req bit is low; (b) owner≠0 and req[0] is high (preemption); (c) owner≠0, the other function requester's req is high, and hold_cnt ≥ MAX_HOLD-1.
REQ-020 Owner 0 SHALL never be preempted or time-limited.
REQ-021 GAP: gnt=0 for exactly GAP_CYC cycles (gap_cnt 4-bit), then go to OWN with the winner re-evaluated on that cycle's req, or to IDLE if req==0.
REQ-022 Requests asserted or dropped during GAP SHALL count only at its final cycle.
REQ-023 hold_cnt SHALL clear on every entry to OWN.
REQ-024 Output mux SHALL be combinational from registered gnt: gnt[i] high selects slice i of mat_in/num_in/beep_in.
REQ-025 When gnt=0, the outputs SHALL be matrixData=128'h0, numbersData=32'hFFFFFFFF (all digits blank code f), and beep=0.
REQ-026 gnt SHALL change only on state transitions, and grant latency from IDLE SHALL be 1 cycle (req high at edge n → gnt valid after edge n+1).
REQ-027 A simultaneous owner release and new request SHALL still pass through GAP; there SHALL be no direct OWN→OWN handover.
REQ-028 MAX_HOLD=0 or 1 SHALL be treated as 1 (forced switch after one cycle when contended).
REQ-029 gnt SHALL never have more than one bit set.

Reset
REQ-030 With sw low at a rising clk edge, the block SHALL set state=IDLE, gnt=0, rr=0, hold_cnt=0, gap_cnt=0, busy=0, with blank outputs per REQ-025, regardless of the current state (including mid-OWN and mid-GAP).
REQ-031 While sw is low, req SHALL be ignored, and the first grant SHALL be possible on the first edge after sw returns high.

Verification
REQ-032 The bench SHALL cover: sw=0 then 1, req=3'b000 → gnt=0, numbersData=FFFFFFFF, matrixData=0, busy=0.
REQ-033 The bench SHALL cover: req=3'b110 from IDLE with rr=0 → gnt=3'b010 after 1 cycle; with MAX_HOLD=4, gnt=010 for 4 cycles, then 000 for GAP_CYC=1 cycle, then 100; rr toggles.
REQ-034 The bench SHALL cover: owner 2 active, req[0] rises → gnt 100→000 next cycle, →001 one cycle later, numbersData=num_in[31:0]; req[0] held 20 cycles with req[2] high → gnt stays 001.
REQ-035 The bench SHALL cover: owner 1 drops req while req[2] rises on the same edge → one GAP cycle, then gnt=100.
REQ-036 The bench SHALL cover: sw pulled low for one cycle mid-OWN (gnt=010) → gnt=0, blank outputs the next cycle, rr=0; after sw high with req=010 → gnt=010 after 1 cycle.
REQ-037 The bench SHALL cover: GAP_CYC=3, req toggled inside GAP → no grant until the third gap cycle ends; the winner is taken from req at that cycle; if req=0 → IDLE.
